// File: rtl/walls_pkg.sv
// Shared types and defaults for the scrolling wall field.
package walls_pkg;

  // Difficulty speed table (centre increments per frame tick, FRAC-scaled).
  localparam logic [5:0] DIFF_SPEED [0:3] = '{6'd6, 6'd9, 6'd12, 6'd15};

  // Default lookup thresholds, in radius units.
  localparam int ISLAND_R_DEF = 28;
  localparam int EDGE_R_DEF   = 32;

  // Refill state: IDLE waits for the centre to change half, FILL pulls rows.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  // Radius class of a lookup point, decided before the ring data is known.
  typedef enum logic [1:0] {
    CLS_WALL   = 2'd0,
    CLS_EDGE   = 2'd1,
    CLS_ISLAND = 2'd2
  } look_cls_t;

  // Island beats edge beats ring data.
  function automatic look_cls_t classify(input int radius, input int island_r,
                                         input int edge_r);
    if (radius < island_r)    return CLS_ISLAND;
    else if (radius < edge_r) return CLS_EDGE;
    else                      return CLS_WALL;
  endfunction

endpackage

// File: rtl/wall_ring_ram.sv
// Wall row ring: one write port, two independent registered read ports.
// A read of the row being written in the same cycle returns the old row.
module wall_ring_ram #(
  parameter  int NSECT = 6,
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [NSECT-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [NSECT-1:0] o_rdata_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [NSECT-1:0] o_rdata_b
);

  logic [NSECT-1:0] r_mem [DEPTH];
  logic [NSECT-1:0] r_rdata_a;
  logic [NSECT-1:0] r_rdata_b;

  // Clear the ring on reset, otherwise write one row and read two rows.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      // NOTE: the ring must read as empty straight after reset, so every row is
      // cleared here; this prevents mapping onto a plain RAM macro.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      // NOTE: non-blocking writes make same-cycle reads see the old row.
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata_a <= r_mem[i_raddr_a];
      r_rdata_b <= r_mem[i_raddr_b];
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/wall_field.sv
// Scrolling wall field: centre position, half-ring refill FSM, draw and
// collision lookups with one cycle of latency.
module wall_field
  import walls_pkg::*;
#(
  parameter  int NSECT       = 6,
  parameter  int DEPTH       = 128,
  parameter  int ROW_SHIFT   = 5,
  parameter  int FRAC        = 2,
  parameter  int SPEEDW      = 6,
  parameter  int RADW        = 10,
  parameter  int ISLAND_R    = ISLAND_R_DEF,
  parameter  int EDGE_R      = EDGE_R_DEF,
  parameter  int CENTER_INIT = 6144,
  localparam int AW          = $clog2(DEPTH),
  localparam int SW          = $clog2(NSECT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic              pause,
  input  logic [SPEEDW-1:0] speed,
  input  logic              pat_valid,
  input  logic [NSECT-1:0]  pat_data,
  output logic              pat_ready,
  output logic [AW-2:0]     pat_row,
  input  logic [SW-1:0]     draw_sector,
  input  logic [RADW-1:0]   draw_radius,
  output logic [SW-1:0]     draw_sector_out,
  output logic              draw_visible,
  output logic              draw_island,
  input  logic [SW-1:0]     col_sector,
  input  logic [RADW-1:0]   col_radius,
  output logic              col_hit,
  output logic [15:0]       rows_passed,
  output logic              underrun
);

  localparam int CW   = AW + ROW_SHIFT + FRAC;  // centre width
  localparam int POSW = AW + ROW_SHIFT;         // integer radius-unit position
  localparam int SUMW = POSW + RADW + 1;
  localparam int SPAN = 1 << SW;                // sector codes incl. unused ones

  // Ring row holding a point at distance rad beyond integer position pos.
  function automatic logic [AW-1:0] row_addr(input logic [POSW-1:0] pos,
                                             input logic [RADW-1:0] rad);
    return AW'((SUMW'(pos) + SUMW'(rad)) >> ROW_SHIFT);
  endfunction

  logic [CW-1:0]    r_centre;
  logic [15:0]      r_rows_passed;
  fill_state_t      r_state;
  logic             r_cur_half;
  logic             r_fill_half;
  logic [AW-2:0]    r_wptr;
  logic             r_pat_ready;
  logic             r_underrun;
  look_cls_t        r_draw_cls, r_col_cls;
  logic [SW-1:0]    r_draw_sect, r_col_sect;

  logic [CW-1:0]    w_centre_next;
  logic [AW-1:0]    w_row_delta;
  logic [16:0]      w_rows_sum;
  logic             w_half;
  logic             w_we;
  logic [AW-1:0]    w_waddr, w_draw_addr, w_col_addr;
  logic [NSECT-1:0] w_draw_row, w_col_row;
  logic [SPAN-1:0]  w_draw_pad, w_col_pad;

  assign w_centre_next = r_centre + CW'(speed);
  assign w_row_delta   = w_centre_next[CW-1 -: AW] - r_centre[CW-1 -: AW];
  assign w_rows_sum    = {1'b0, r_rows_passed} + 17'(w_row_delta);
  assign w_half        = r_centre[CW-1];
  assign w_we          = pat_valid & r_pat_ready;
  assign w_waddr       = {r_fill_half, r_wptr};
  assign w_draw_addr   = row_addr(r_centre[CW-1:FRAC], draw_radius);
  assign w_col_addr    = row_addr(r_centre[CW-1:FRAC], col_radius);

  // Advance the centre on unpaused frame ticks and count rows crossed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_centre      <= CW'(CENTER_INIT);
      r_rows_passed <= '0;
    end else if (update && !pause) begin
      r_centre      <= w_centre_next;
      r_rows_passed <= w_rows_sum[16] ? 16'hFFFF : w_rows_sum[15:0];
    end
  end

  // Refill FSM: a half change always restarts a fill of the half just left.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_cur_half  <= 1'b0;
      r_fill_half <= 1'b1;
      r_wptr      <= '0;
      r_pat_ready <= 1'b1;
      r_underrun  <= 1'b0;
    end else if (w_half != r_cur_half) begin
      r_cur_half  <= w_half;
      r_fill_half <= ~w_half;
      r_state     <= ST_FILL;
      r_wptr      <= '0;
      r_pat_ready <= 1'b1;
      if (r_state == ST_FILL) r_underrun <= 1'b1;
    end else if (r_state == ST_FILL && pat_valid) begin
      if (&r_wptr) begin
        r_state     <= ST_IDLE;
        r_pat_ready <= 1'b0;
        r_wptr      <= '0;
      end else begin
        r_wptr <= r_wptr + (AW-1)'(1);
      end
    end
  end

  // Register radius class and sector alongside the ring read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_draw_cls  <= CLS_WALL;
      r_col_cls   <= CLS_WALL;
      r_draw_sect <= '0;
      r_col_sect  <= '0;
    end else begin
      r_draw_cls  <= classify(int'(draw_radius), ISLAND_R, EDGE_R);
      r_col_cls   <= classify(int'(col_radius), ISLAND_R, EDGE_R);
      r_draw_sect <= draw_sector;
      r_col_sect  <= col_sector;
    end
  end

  wall_ring_ram #(.NSECT(NSECT), .DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .i_reset   (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (pat_data),
    .i_raddr_a (w_draw_addr),
    .o_rdata_a (w_draw_row),
    .i_raddr_b (w_col_addr),
    .o_rdata_b (w_col_row)
  );

  // Zero-padding to every sector code makes unused sectors read as empty.
  assign w_draw_pad      = SPAN'(w_draw_row);
  assign w_col_pad       = SPAN'(w_col_row);
  assign draw_visible    = (r_draw_cls == CLS_EDGE) |
                           ((r_draw_cls == CLS_WALL) & w_draw_pad[r_draw_sect]);
  assign draw_island     = (r_draw_cls == CLS_ISLAND);
  assign col_hit         = (r_col_cls == CLS_WALL) & w_col_pad[r_col_sect];
  assign draw_sector_out = r_draw_sect;
  assign pat_ready       = r_pat_ready;
  assign pat_row         = r_wptr;
  assign rows_passed     = r_rows_passed;
  assign underrun        = r_underrun;

endmodule

// File: tb/tb_wall_field.sv
// Self-checking bench for wall_field against a behavioural model of the
// scrolling ring, refill handshake and lookup rules.
module tb_wall_field;

  logic       clk, reset, update, pause, pat_valid, pat_ready;
  logic [5:0] speed, pat_data, pat_row;
  logic [2:0] draw_sector, draw_sector_out, col_sector;
  logic [9:0] draw_radius, col_radius;
  logic       draw_visible, draw_island, col_hit, underrun;
  logic [15:0] rows_passed;

  wall_field dut (
    .clk(clk), .reset(reset), .update(update), .pause(pause), .speed(speed),
    .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(pat_ready),
    .pat_row(pat_row), .draw_sector(draw_sector), .draw_radius(draw_radius),
    .draw_sector_out(draw_sector_out), .draw_visible(draw_visible),
    .draw_island(draw_island), .col_sector(col_sector), .col_radius(col_radius),
    .col_hit(col_hit), .rows_passed(rows_passed), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: centre in quarter radius units, ring of 128 rows.
  int m_ring [128];
  int m_centre, m_cur_half, m_fill_half, m_active, m_wcount, m_rows, m_underrun;
  int e_dso, e_vis, e_isl, e_hit;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int look_row(input int c, input int r);
    return (((c / 4) + r) / 32) % 128;
  endfunction

  // Visible/hit bit of a point: island and edge override ring data.
  function automatic void lookup(input int rad, input int sec, output int vis,
                                 output int isl, output int hit);
    int bit_v;
    bit_v = (sec < 6) ? ((m_ring[look_row(m_centre, rad)] >> sec) & 1) : 0;
    isl = (rad < 28) ? 1 : 0;
    vis = (rad < 28) ? 0 : (rad < 32) ? 1 : bit_v;
    hit = (rad < 32) ? 0 : bit_v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_ring[i] = 0;
    m_centre = 6144; m_cur_half = 0; m_fill_half = 1; m_active = 1;
    m_wcount = 0; m_rows = 0; m_underrun = 0;
    e_dso = 0; e_vis = 0; e_isl = 0; e_hit = 0;
  endtask

  // What one clock edge does given the inputs currently driven.
  task automatic model_edge();
    int v, i, h, old_row, new_row, half_now;
    if (reset) begin
      model_reset();
      return;
    end
    e_dso = draw_sector;
    lookup(draw_radius, draw_sector, e_vis, e_isl, h);
    lookup(col_radius, col_sector, v, i, e_hit);
    if (m_active && pat_valid) begin
      m_ring[m_fill_half * 64 + m_wcount] = pat_data;
      m_wcount++;
      if (m_wcount == 64) begin
        m_active = 0;
        m_wcount = 0;
      end
    end
    half_now = ((m_centre / 128) % 128 >= 64) ? 1 : 0;
    if (half_now != m_cur_half) begin
      if (m_active) m_underrun = 1;
      m_cur_half = half_now; m_fill_half = 1 - half_now;
      m_active = 1; m_wcount = 0;
    end
    if (update && !pause) begin
      old_row  = m_centre / 128;
      m_centre = (m_centre + speed) % 16384;
      new_row  = m_centre / 128;
      m_rows   = m_rows + ((new_row - old_row + 128) % 128);
      if (m_rows > 65535) m_rows = 65535;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("draw_sector_out", draw_sector_out, e_dso);
    check("draw_visible", draw_visible, e_vis);
    check("draw_island", draw_island, e_isl);
    check("col_hit", col_hit, e_hit);
    check("pat_ready", pat_ready, m_active);
    check("pat_row", pat_row, m_wcount);
    check("rows_passed", rows_passed, m_rows);
    check("underrun", underrun, m_underrun);
  endtask

  task automatic rand_look();
    draw_sector = 3'($urandom_range(0, 7));
    col_sector  = 3'($urandom_range(0, 7));
    draw_radius = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 40))
                                              : 10'($urandom_range(0, 1023));
    col_radius  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 40))
                                              : 10'($urandom_range(0, 1023));
  endtask

  initial begin
    int dut_acc, cnt, rows_saved;
    reset = 1'b1; update = 1'b0; pause = 1'b0; speed = '0; pat_valid = 1'b0;
    pat_data = '0; draw_sector = '0; draw_radius = '0; col_sector = '0; col_radius = '0;

    // Reset state.
    tick();
    tick();
    check("rst_pat_ready", pat_ready, 1);
    check("rst_pat_row", pat_row, 0);
    check("rst_island", draw_island, 0);
    check("rst_underrun", underrun, 0);
    reset = 1'b0;

    // Initial fill of rows 64..127.
    pat_valid = 1'b1;
    dut_acc = 0;
    for (int k = 0; k < 66; k++) begin
      pat_data = 6'($urandom_range(0, 63));
      rand_look();
      if (pat_ready === 1'b1) dut_acc++;
      tick();
    end
    pat_valid = 1'b0;
    check("fill_accepted", dut_acc, 64);
    check("fill_idle_ready", pat_ready, 0);

    // Directed lookup classes.
    draw_sector = 3'd2; col_sector = 3'd2;
    draw_radius = 10'd20; col_radius = 10'd20; tick();
    check("r20_island", draw_island, 1);
    check("r20_visible", draw_visible, 0);
    draw_radius = 10'd30; col_radius = 10'd30; tick();
    check("r30_visible", draw_visible, 1);
    check("r30_hit", col_hit, 0);
    draw_radius = 10'd40; col_radius = 10'd600; tick();
    check("r40_visible_row49_empty", draw_visible, 0);
    for (int k = 0; k < 40; k++) begin
      rand_look();
      tick();
    end

    // Scroll at speed 15 until the centre enters the upper half.
    speed = 6'd15; update = 1'b1; cnt = 0;
    while (m_cur_half == 0 && cnt < 400) begin
      rand_look();
      tick();
      cnt++;
    end
    update = 1'b0;
    check("cross_within_bound", cnt < 400, 1);
    check("cross_pat_ready", pat_ready, 1);
    check("cross_rows_delta", rows_passed, m_centre / 128 - 48);
    pat_valid = 1'b1;
    for (int k = 0; k < 70; k++) begin
      pat_data = 6'($urandom_range(0, 63));
      rand_look();
      tick();
    end
    pat_valid = 1'b0;
    check("refill_idle", pat_ready, 0);

    // Pause holds the centre still.
    rows_saved = m_rows;
    pause = 1'b1; update = 1'b1; speed = 6'd37;
    for (int k = 0; k < 10; k++) begin
      rand_look();
      tick();
    end
    pause = 1'b0; update = 1'b0;
    check("pause_rows", rows_passed, rows_saved);

    // Half crossing from IDLE, partial fill, then crossing again: underrun.
    speed = 6'd63; update = 1'b1; cnt = 0;
    while (m_cur_half == 1 && cnt < 400) begin
      rand_look();
      tick();
      cnt++;
    end
    update = 1'b0;
    check("cross2_pat_ready", pat_ready, 1);
    check("cross2_no_underrun", underrun, 0);
    pat_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pat_data = 6'($urandom_range(0, 63));
      tick();
    end
    pat_valid = 1'b0;
    check("partial_pat_row", pat_row, 10);
    update = 1'b1; cnt = 0;
    while (m_cur_half == 0 && cnt < 400) begin
      rand_look();
      tick();
      cnt++;
    end
    update = 1'b0;
    check("underrun_set", underrun, 1);
    check("underrun_restart_row", pat_row, 0);
    check("underrun_ready", pat_ready, 1);

    // Reset in the middle of a fill and an update.
    pat_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pat_data = 6'($urandom_range(0, 63));
      tick();
    end
    reset = 1'b1; update = 1'b1;
    tick();
    check("midrst_pat_row", pat_row, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_rows", rows_passed, 0);
    reset = 1'b0; update = 1'b0; pat_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rand_look();
      tick();
    end
    update = 1'b1; speed = 6'd63;
    for (int k = 0; k < 40; k++) begin
      rand_look();
      tick();
    end
    update = 1'b0;
    check("post_rst_rows", rows_passed, (6144 + 40 * 63) / 128 - 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
